cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 for the five-stage MIPS core. Sits in the M stage next to the data-memory path.
- Holds SR, Cause, EPC and PRId, and serves mfc0/mtc0/eret.
- Merges M-stage exception codes with the six external hardware interrupt lines.
- Drives the global flush request (req) that redirects fetch to the handler and clears every pipeline register, including M_W_REG.
- Supplies the CP0 read data (registered into W stage) and the EPC value.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address driven on handler_pc.
- PRID_VAL, 32'h2022_0801, constant value returned for PRId (reg 15).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  mtc0 write strobe from the M-stage instruction
- cp0_addr  input  5  CP0 register number (rd field) for read and write
- cp0_wdata  input  32  mtc0 data (forwarded rt value)
- cp0_rdata  output  32  combinational mfc0 read data
- vpc  input  32  PC of the instruction currently in M (macroscopic PC)
- bd_in  input  1  M instruction is in a branch delay slot
- exc_code_in  input  5  pipelined exception code of the M instruction; 0 = none
- eret_in  input  1  M instruction is eret
- hw_int  input  6  external interrupt lines (timer0, timer1, interrupt generator, ...)
- req  output  1  combinational flush/redirect request
- handler_pc  output  32  constant HANDLER_PC
- epc_out  output  32  current EPC register value

Behaviour:
- Registers, all updated on posedge clk:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits, bits[1:0] always 0.
  - PRId (15): constant PRID_VAL.
- Reset (synchronous): SR=0, Cause=0, EPC=0.
  - req=0 while reset is high.
  - cp0_rdata still reflects addr decode of the reset values.
- Request logic (combinational):
  - int_req = (|(hw_int & SR.IM)) & SR.IE & ~SR.EXL.
  - exc_req = (exc_code_in != 0) & ~SR.EXL.
  - req = (int_req | exc_req) & ~reset.
  - Interrupt has priority over an exception on the same instruction.
- On a clock edge with req=1:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= (bd_in ? vpc - 4 : vpc) with bits[1:0] cleared.
  - The mtc0 write is suppressed (the instruction is being flushed).
  - eret_in is ignored (eret never coexists with EXL=0 req in legal code; req still wins).
- IP: Cause.IP <= hw_int every cycle, independent of req, EXL and mtc0.
- eret: on an edge with eret_in=1 and req=0, EXL <= 0. No other field changes.
- mtc0: on an edge with wr_en=1 and req=0:
  - addr 12: IM, EXL and IE loaded from cp0_wdata[15:10], [1], [0].
  - addr 14: EPC <= {cp0_wdata[31:2], 2'b00}.
  - addr 13, 15 and all others: write ignored.
- Same-edge mtc0 SR and eret: mtc0 value loads first, then EXL is cleared (eret dominates on EXL).
- Read (combinational): addr 12/13/14/15 return the masked register; any other addr returns 0. Value is the pre-edge state, with no internal write bypass.
- epc_out is the raw EPC register. mtc0-EPC to eret hazards are resolved by the stall unit, not here.
- Latency:
  - req is asserted in the same cycle the faulting instruction is in M.
  - The handler's first instruction is fetched on the following cycle.
  - SR/Cause/EPC are visible to mfc0 one cycle after the triggering edge.

Test Plan:
- Reset, then read addr 12/13/14/15 -> 0, 0, 0, 32'h2022_0801; req=0 even with exc_code_in=5'd4 held during reset.
- mtc0 SR=32'h0000_0401 (IM[10], IE), then hw_int=6'b000001 with vpc=32'h3010, bd_in=0 -> req=1 that cycle; next cycle EXL=1, ExcCode=0, EPC=32'h3010, IP=1; req stays 0 while EXL=1.
- exc_code_in=5'd10 (RI), vpc=32'h3024, bd_in=1, SR=0 -> req=1; next cycle Cause=32'h8000_0028, EPC=32'h3020.
- exc_code_in=5'd12 together with an enabled interrupt -> ExcCode=0 (interrupt wins), EPC=vpc.
- wr_en=1, addr=14, wdata=32'h0000_3007 with req=0 -> EPC=32'h3004; the same write with req=1 -> EPC takes the exception PC, not the write data.
- EXL=1, eret_in=1 -> EXL=0 next cycle; a pending enabled interrupt raises req on the following cycle; mtc0 to Cause ignored, while IP keeps tracking hw_int each cycle.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the five-stage core: SR/Cause/EPC/PRId, mfc0/mtc0/eret,
// and the combinational flush request that redirects fetch to the handler.
module cp0_unit #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2022_0801
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        eret_in,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [29:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_target;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] epc_val;

  assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
  assign req     = (int_req | exc_req) & ~reset;

  // A delay-slot fault restarts at the branch, so EPC points one word back.
  assign epc_target = bd_in ? (vpc - 32'd4) : vpc;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : exc_code_in;
      bd_d       = bd_in;
      epc_d      = epc_target[31:2];
    end else begin
      if (wr_en && (cp0_addr == ADDR_SR)) begin
        im_d  = cp0_wdata[15:10];
        exl_d = cp0_wdata[1];
        ie_d  = cp0_wdata[0];
      end
      if (wr_en && (cp0_addr == ADDR_EPC)) begin
        epc_d = cp0_wdata[31:2];
      end
      // eret is applied after the SR write so it wins on EXL.
      if (eret_in) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 30'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
  assign epc_val   = {epc_q, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = sr_val;
      ADDR_CAUSE: cp0_rdata = cause_val;
      ADDR_EPC:   cp0_rdata = epc_val;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign handler_pc = HANDLER_PC;
  assign epc_out    = epc_val;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios plus randomized traffic, all checked
// against a word-level model of SR/Cause/EPC kept in the bench.
module tb_cp0_unit;

  localparam logic [31:0] HPC  = 32'h0000_4180;
  localparam logic [31:0] PRID = 32'h2022_0801;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret_in;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0_unit dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .vpc(vpc), .bd_in(bd_in),
    .exc_code_in(exc_code_in), .eret_in(eret_in), .hw_int(hw_int),
    .req(req), .handler_pc(handler_pc), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_int();
    return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic model_req();
    return (model_int() || ((exc_code_in != 5'd0) && !m_sr[1])) && !reset;
  endfunction

  // Check combinational outputs, then advance the model and the DUT one edge.
  task automatic step();
    logic [31:0] n_sr, n_cause, n_epc;
    logic        r;
    #1;
    r = model_req();
    chk("req", {31'd0, req}, {31'd0, r});
    chk("rdata", cp0_rdata, model_read(cp0_addr));
    chk("epc_out", epc_out, m_epc);
    chk("handler_pc", handler_pc, HPC);
    n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
    if (reset) begin
      n_sr = 0; n_cause = 0; n_epc = 0;
    end else begin
      n_cause[15:10] = hw_int;
      if (r) begin
        n_sr[1]       = 1'b1;
        n_cause[31]   = bd_in;
        n_cause[6:2]  = model_int() ? 5'd0 : exc_code_in;
        n_epc         = (bd_in ? vpc - 32'd4 : vpc) & 32'hFFFF_FFFC;
      end else begin
        if (wr_en && cp0_addr == 5'd12) n_sr = cp0_wdata & 32'h0000_FC03;
        if (wr_en && cp0_addr == 5'd14) n_epc = cp0_wdata & 32'hFFFF_FFFC;
        if (eret_in) n_sr[1] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
  endtask

  task automatic idle();
    reset = 0; wr_en = 0; cp0_addr = 5'd0; cp0_wdata = 0; vpc = 0;
    bd_in = 0; exc_code_in = 0; eret_in = 0;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  initial begin
    idle();
    hw_int = 0;
    reset  = 1;
    repeat (2) @(posedge clk);
    #1;
    m_sr = 0; m_cause = 0; m_epc = 0;

    // reset holds req low even with a pending exception code
    exc_code_in = 5'd4;
    #1 chk("req_in_reset", {31'd0, req}, 32'd0);
    step();
    idle();
    read_chk("rst_sr", 5'd12, 32'd0);
    read_chk("rst_cause", 5'd13, 32'd0);
    read_chk("rst_epc", 5'd14, 32'd0);
    read_chk("rst_prid", 5'd15, PRID);
    step();

    // interrupt entry
    wr_en = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    step();
    idle(); hw_int = 6'b000001; vpc = 32'h3010;
    #1 chk("int_req", {31'd0, req}, 32'd1);
    step();
    idle();
    read_chk("int_sr", 5'd12, 32'h0000_0403);
    read_chk("int_cause", 5'd13, 32'h0000_0400);
    read_chk("int_epc", 5'd14, 32'h0000_3010);
    chk("exl_blocks_req", {31'd0, req}, 32'd0);
    step();

    // exception in a delay slot with interrupts off
    wr_en = 1; cp0_addr = 5'd12; cp0_wdata = 0; hw_int = 0;
    step();
    idle(); exc_code_in = 5'd10; vpc = 32'h3024; bd_in = 1;
    #1 chk("exc_req", {31'd0, req}, 32'd1);
    step();
    idle();
    read_chk("exc_cause", 5'd13, 32'h8000_0028);
    read_chk("exc_epc", 5'd14, 32'h0000_3020);
    step();

    // interrupt beats a same-instruction exception
    wr_en = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    step();
    idle(); hw_int = 6'b000001; exc_code_in = 5'd12; vpc = 32'h3100;
    step();
    idle();
    read_chk("prio_cause", 5'd13, 32'h0000_0400);
    read_chk("prio_epc", 5'd14, 32'h0000_3100);

    // EPC write, then same write overridden by an exception
    hw_int = 0; wr_en = 1; cp0_addr = 5'd12; cp0_wdata = 0;
    step();
    idle(); wr_en = 1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
    step();
    idle();
    read_chk("mtc0_epc", 5'd14, 32'h0000_3004);
    wr_en = 1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
    exc_code_in = 5'd4; vpc = 32'h3200;
    step();
    idle();
    read_chk("req_beats_mtc0", 5'd14, 32'h0000_3200);

    // eret releases a pending interrupt; Cause writes ignored, IP tracks
    wr_en = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403; hw_int = 6'b000001;
    step();
    idle();
    #1 chk("pending_held", {31'd0, req}, 32'd0);
    eret_in = 1; wr_en = 1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF; hw_int = 6'b000010;
    step();
    idle();
    read_chk("eret_sr", 5'd12, 32'h0000_0401);
    read_chk("cause_ignored", 5'd13, 32'h0000_0810);
    hw_int = 6'b000001;
    #1 chk("req_after_eret", {31'd0, req}, 32'd1);
    step();
    idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      wr_en       = ($urandom_range(0, 3) == 0);
      cp0_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'(12 + $urandom_range(0, 3));
      cp0_wdata   = $urandom;
      vpc         = $urandom;
      bd_in       = $urandom_range(0, 1) == 1;
      exc_code_in = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      eret_in     = ($urandom_range(0, 7) == 0);
      hw_int      = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'd0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
